side_buffer: RTL and testbench

Side buffer stage of the MinBD router, directly downstream of the redirect stage. Captures flits the redirect stage pulls off a fully occupied cycle (`buffit`) into a small FIFO. Re-injects the oldest buffered flit into the first free output channel on later cycles. Also owns the 3-bit starvation counter (`cthulhu`) that the redirect stage compares against 5 to decide when to pull a flit.

---
 rtl/minbd_pkg.sv | 28 ++
 rtl/side_buffer_if.sv | 39 +++
 rtl/side_buffer_fifo.sv | 63 ++++++
 rtl/side_buffer.sv | 113 +++++++++++
 tb/tb_side_buffer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/minbd_pkg.sv
// rtl/minbd_pkg.sv - shared MinBD router types and constants
package minbd_pkg;

    localparam int FLIT_W = 11;
    localparam logic [2:0] STARVE_MAX = 3'd5;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_S = 2'd1,
        PORT_E = 2'd2,
        PORT_W = 2'd3
    } port_e;

    // Lowest-numbered free channel wins (N, S, E, W); returns PORT_N when none is free.
    function automatic port_e first_free(input logic [3:0] valid);
        port_e sel;
        sel = PORT_N;
        for (int i = 3; i >= 0; i--) begin
            if (!valid[i]) begin
                sel = port_e'(i[1:0]);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/side_buffer_if.sv
// rtl/side_buffer_if.sv - channel, buffer and status signals of the side buffer
interface side_buffer_if #(
    parameter int DEPTH = 4
) ();
    import minbd_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    flit_t          buf_in;
    logic           buf_in_valid;
    flit_t          n_in, s_in, e_in, w_in;
    logic           n_in_valid, s_in_valid, e_in_valid, w_in_valid;
    flit_t          n_out, s_out, e_out, w_out;
    logic           n_out_valid, s_out_valid, e_out_valid, w_out_valid;
    logic [2:0]     cthulhu;
    logic [CW-1:0]  count;
    logic           empty;
    logic           full;
    logic           overflow;

    modport master (
        output buf_in, buf_in_valid,
        output n_in, s_in, e_in, w_in,
        output n_in_valid, s_in_valid, e_in_valid, w_in_valid,
        input  n_out, s_out, e_out, w_out,
        input  n_out_valid, s_out_valid, e_out_valid, w_out_valid,
        input  cthulhu, count, empty, full, overflow
    );

    modport slave (
        input  buf_in, buf_in_valid,
        input  n_in, s_in, e_in, w_in,
        input  n_in_valid, s_in_valid, e_in_valid, w_in_valid,
        output n_out, s_out, e_out, w_out,
        output n_out_valid, s_out_valid, e_out_valid, w_out_valid,
        output cthulhu, count, empty, full, overflow
    );

endinterface

// File: rtl/side_buffer_fifo.sv
// rtl/side_buffer_fifo.sv - synchronous FIFO holding flits pulled off by the redirect stage
module side_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reflects the pre-push state, so a flit written this cycle is never read this cycle.
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/side_buffer.sv
// rtl/side_buffer.sv - MinBD side buffer: captures redirected flits and re-injects them into free channels
module side_buffer #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    side_buffer_if.slave bus
);
    import minbd_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    flit_t         ch_in   [4];
    flit_t         ch_out  [4];
    logic [3:0]    ch_valid;
    logic [3:0]    out_valid;
    logic [3:0]    inject;
    port_e         sel;
    logic          any_free;
    logic          push;
    logic          pop;
    flit_t         head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [2:0]    cthulhu;
    logic          overflow;

    assign ch_in[PORT_N] = bus.n_in;
    assign ch_in[PORT_S] = bus.s_in;
    assign ch_in[PORT_E] = bus.e_in;
    assign ch_in[PORT_W] = bus.w_in;
    assign ch_valid      = {bus.w_in_valid, bus.e_in_valid, bus.s_in_valid, bus.n_in_valid};

    assign any_free = ~&ch_valid;
    assign sel      = first_free(ch_valid);
    assign push     = bus.buf_in_valid && !full;
    assign pop      = any_free && !empty;

    always_comb begin
        inject = '0;
        for (int i = 0; i < 4; i++) begin
            inject[i] = pop && (sel == port_e'(i[1:0]));
        end
    end

    side_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.buf_in),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ch_out[i] <= '0;
            end
            out_valid <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ch_out[i] <= inject[i] ? head : ch_in[i];
            end
            out_valid <= ch_valid | inject;
        end
    end

    // A full buffer forces cthulhu low so the redirect stage stops pulling flits it cannot store.
    always_ff @(posedge clk) begin
        if (rst) begin
            cthulhu <= '0;
        end else if (empty) begin
            cthulhu <= '0;
        end else if (full) begin
            cthulhu <= '0;
        end else if (pop) begin
            cthulhu <= '0;
        end else if (&ch_valid) begin
            cthulhu <= (cthulhu >= STARVE_MAX) ? STARVE_MAX : cthulhu + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (bus.buf_in_valid && full) begin
            overflow <= 1'b1;
        end
    end

    assign bus.n_out       = ch_out[PORT_N];
    assign bus.s_out       = ch_out[PORT_S];
    assign bus.e_out       = ch_out[PORT_E];
    assign bus.w_out       = ch_out[PORT_W];
    assign bus.n_out_valid = out_valid[PORT_N];
    assign bus.s_out_valid = out_valid[PORT_S];
    assign bus.e_out_valid = out_valid[PORT_E];
    assign bus.w_out_valid = out_valid[PORT_W];
    assign bus.cthulhu     = cthulhu;
    assign bus.count       = count;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.overflow    = overflow;

endmodule

// File: tb/tb_side_buffer.sv
// tb/tb_side_buffer.sv - directed self-checking bench for side_buffer
module tb_side_buffer;
    import minbd_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    side_buffer_if #(.DEPTH(4)) bus ();

    side_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // valid bits: [0]=N [1]=S [2]=E [3]=W; channel data is a fixed tag per port
    task automatic set_in(input logic [3:0] v, input logic bv, input logic [10:0] b);
        bus.n_in         = 11'h011;
        bus.s_in         = 11'h022;
        bus.e_in         = 11'h033;
        bus.w_in         = 11'h044;
        bus.n_in_valid   = v[0];
        bus.s_in_valid   = v[1];
        bus.e_in_valid   = v[2];
        bus.w_in_valid   = v[3];
        bus.buf_in       = b;
        bus.buf_in_valid = bv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_c [7];
        exp_c[0] = 3'd1; exp_c[1] = 3'd2; exp_c[2] = 3'd3; exp_c[3] = 3'd4;
        exp_c[4] = 3'd5; exp_c[5] = 3'd5; exp_c[6] = 3'd5;
        tests  = 0;
        failed = 0;

        // reset with a push and busy channels presented: all must be ignored
        rst = 1'b1;
        set_in(4'hF, 1'b1, 11'h3FF);
        tick();
        check("rst_n_valid", bus.n_out_valid, 0);
        check("rst_w_valid", bus.w_out_valid, 0);
        check("rst_n_out", bus.n_out, 0);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_cthulhu", bus.cthulhu, 0);
        rst = 1'b0;

        // single push with N busy lands in S
        set_in(4'b0001, 1'b1, 11'h155);
        tick();
        check("t1_count_push", bus.count, 1);
        check("t1_s_valid_pre", bus.s_out_valid, 0);
        set_in(4'b0001, 1'b0, 11'h000);
        tick();
        check("t1_s_out", bus.s_out, 11'h155);
        check("t1_s_valid", bus.s_out_valid, 1);
        check("t1_n_out", bus.n_out, 11'h011);
        check("t1_n_valid", bus.n_out_valid, 1);
        check("t1_e_valid", bus.e_out_valid, 0);
        check("t1_count", bus.count, 0);
        check("t1_cthulhu", bus.cthulhu, 0);

        // fill to full under all-busy channels
        for (int k = 0; k < 4; k++) begin
            set_in(4'hF, 1'b1, 11'h101 + 11'(k));
            tick();
        end
        check("t2_full", bus.full, 1);
        check("t2_count", bus.count, 4);
        check("t2_cthulhu_ramp", bus.cthulhu, 3);
        set_in(4'hF, 1'b1, 11'h105);
        tick();
        check("t3_ovf", bus.overflow, 1);
        check("t3_count", bus.count, 4);
        check("t3_cthulhu_full", bus.cthulhu, 0);
        set_in(4'hF, 1'b0, 11'h000);
        tick();
        check("t3_cthulhu_hold", bus.cthulhu, 0);
        for (int k = 0; k < 4; k++) begin
            set_in(4'b0111, 1'b0, 11'h000);
            tick();
            check($sformatf("t3_w_out%0d", k), bus.w_out, 11'h101 + 11'(k));
            check($sformatf("t3_w_valid%0d", k), bus.w_out_valid, 1);
            check($sformatf("t3_count%0d", k), bus.count, 3 - k);
        end
        check("t3_empty", bus.empty, 1);
        check("t3_ovf_sticky", bus.overflow, 1);

        // starvation ramp with one flit buffered
        set_in(4'hF, 1'b1, 11'h1AA);
        tick();
        check("t4_cthulhu0", bus.cthulhu, 0);
        for (int k = 0; k < 7; k++) begin
            set_in(4'hF, 1'b0, 11'h000);
            tick();
            check($sformatf("t4_cthulhu_%0d", k), bus.cthulhu, exp_c[k]);
        end
        set_in(4'b1110, 1'b0, 11'h000);
        tick();
        check("t4_n_out", bus.n_out, 11'h1AA);
        check("t4_n_valid", bus.n_out_valid, 1);
        check("t4_cthulhu_pop", bus.cthulhu, 0);
        check("t4_count", bus.count, 0);

        // simultaneous push and pop with two flits stored
        set_in(4'hF, 1'b1, 11'h0A1);
        tick();
        set_in(4'hF, 1'b1, 11'h0A2);
        tick();
        check("t5_count2", bus.count, 2);
        set_in(4'b1101, 1'b1, 11'h0A3);
        tick();
        check("t5_count_pp", bus.count, 2);
        check("t5_s_out0", bus.s_out, 11'h0A1);
        set_in(4'b1101, 1'b0, 11'h000);
        tick();
        check("t5_s_out1", bus.s_out, 11'h0A2);
        tick();
        check("t5_s_out2", bus.s_out, 11'h0A3);
        check("t5_count0", bus.count, 0);

        // mid-operation reset
        for (int k = 0; k < 3; k++) begin
            set_in(4'hF, 1'b1, 11'h1C0 + 11'(k));
            tick();
        end
        set_in(4'hF, 1'b0, 11'h000);
        tick();
        tick();
        check("t6_count3", bus.count, 3);
        check("t6_cthulhu4", bus.cthulhu, 4);
        rst = 1'b1;
        set_in(4'hF, 1'b1, 11'h1EE);
        tick();
        rst = 1'b0;
        check("t6_count", bus.count, 0);
        check("t6_empty", bus.empty, 1);
        check("t6_cthulhu", bus.cthulhu, 0);
        check("t6_valids", {bus.w_out_valid, bus.e_out_valid, bus.s_out_valid, bus.n_out_valid}, 0);
        check("t6_ovf", bus.overflow, 0);
        set_in(4'h0, 1'b0, 11'h000);
        tick();
        check("t6_no_push", bus.count, 0);
        check("t6_no_inject", bus.n_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
